// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
package controller_pkg;

  // Controller states, numbered in sequencing order for the debug port.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_FAULT  = 4'd10
  } state_t;

  // Data-processing cmd field, instruction[24:21].
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  // ALU control encodings.
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // Datapath mux select encodings.
  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALU    = 1'b1;
  localparam logic       SRCA_REG   = 1'b0;
  localparam logic       SRCA_PC    = 1'b1;
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Commands that only set flags and must not write the register file.
  function automatic logic cmdNoWrite(input logic [3:0] cmd);
    return cmd == CMD_CMP;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction fields, memory handshake and control outputs of the controller.
interface multicycle_controller_if;
  logic [1:0] op_i;
  logic [5:0] funct_i;
  logic [3:0] rd_i;
  logic       mem_ready_i;

  logic       ir_w_o;
  logic       pc_w_o;
  logic       branch_o;
  logic       pcs_o;
  logic       reg_w_o;
  logic       mem_w_o;
  logic       adr_src_o;
  logic       alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [1:0] result_src_o;
  logic [1:0] imm_src_o;
  logic [1:0] reg_src_o;
  logic [1:0] alu_ctl_o;
  logic [1:0] flag_w_o;
  logic       no_write_o;
  logic       shift_o;
  logic       fault_o;
  logic [3:0] state_o;

  // The controller drives the control lines.
  modport master (
    input  op_i, funct_i, rd_i, mem_ready_i,
    output ir_w_o, pc_w_o, branch_o, pcs_o, reg_w_o, mem_w_o, adr_src_o,
           alu_src_a_o, alu_src_b_o, result_src_o, imm_src_o, reg_src_o,
           alu_ctl_o, flag_w_o, no_write_o, shift_o, fault_o, state_o
  );

  // The datapath side supplies instruction fields and memory readiness.
  modport slave (
    output op_i, funct_i, rd_i, mem_ready_i,
    input  ir_w_o, pc_w_o, branch_o, pcs_o, reg_w_o, mem_w_o, adr_src_o,
           alu_src_a_o, alu_src_b_o, result_src_o, imm_src_o, reg_src_o,
           alu_ctl_o, flag_w_o, no_write_o, shift_o, fault_o, state_o
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps the data-processing cmd and S bit to ALU control and flag writes.
module AluDecoder
  import controller_pkg::*;
(
  input  logic       alu_op_i,
  input  logic [3:0] cmd_i,
  input  logic       s_i,
  output logic [1:0] alu_ctl_o,
  output logic [1:0] flag_w_o,
  output logic       no_write_o,
  output logic       shift_o
);

  // Decode only when the FSM requests it; otherwise a plain add with no flags.
  always_comb begin
    alu_ctl_o  = ALU_ADD;
    flag_w_o   = 2'b00;
    no_write_o = 1'b0;
    shift_o    = 1'b0;
    if (alu_op_i) begin
      case (cmd_i)
        CMD_ADD: alu_ctl_o = ALU_ADD;
        CMD_SUB: alu_ctl_o = ALU_SUB;
        CMD_AND: alu_ctl_o = ALU_AND;
        CMD_ORR: alu_ctl_o = ALU_ORR;
        CMD_CMP: begin
          alu_ctl_o  = ALU_SUB;
          no_write_o = 1'b1;
        end
        CMD_MOV: begin
          alu_ctl_o = ALU_ADD;
          shift_o   = 1'b1;
        end
        default: alu_ctl_o = ALU_ADD;
      endcase
      flag_w_o[1] = s_i;
      flag_w_o[0] = s_i & ((cmd_i == CMD_ADD) || (cmd_i == CMD_SUB) || (cmd_i == CMD_CMP));
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM control FSM with memory-ready handshake and bounded wait timeout.
module multicycle_controller
  import controller_pkg::*;
#(
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter int unsigned MAX_WAIT      = 0
) (
  input logic                      clk,
  input logic                      reset,
  multicycle_controller_if.master  ctrl
);

  // The timeout only exists when memory can actually stall us.
  localparam bit WAIT_EN = MEM_HANDSHAKE && (MAX_WAIT > 0);
  localparam int CW      = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

  state_t        state_q, state_d;
  logic [CW-1:0] waitCnt_q, waitCnt_d;
  logic          fault_q, fault_d;

  logic          ready;
  logic          isWaitState;
  logic          timeout;
  logic          aluOp;
  logic          regW;
  logic          branchW;
  logic [1:0]    decAluCtl;
  logic [1:0]    decFlagW;
  logic          decNoWrite;
  logic          decShift;

  assign ready       = MEM_HANDSHAKE ? ctrl.mem_ready_i : 1'b1;
  assign isWaitState = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign aluOp       = (state_q == S_EXECR) || (state_q == S_EXECI);

  AluDecoder u_alu_decoder (
    .alu_op_i   (aluOp),
    .cmd_i      (ctrl.funct_i[4:1]),
    .s_i        (ctrl.funct_i[0]),
    .alu_ctl_o  (decAluCtl),
    .flag_w_o   (decFlagW),
    .no_write_o (decNoWrite),
    .shift_o    (decShift)
  );

  // Next-state sequencing; a stall past the wait limit overrides to FAULT.
  always_comb begin
    state_d = state_q;
    timeout = WAIT_EN && isWaitState && !ready && (waitCnt_q == WAIT_LIMIT);
    case (state_q)
      S_FETCH:  if (ready) state_d = S_DECODE;
      S_DECODE: begin
        case (ctrl.op_i)
          2'b00:   state_d = ctrl.funct_i[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = ctrl.funct_i[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (ready) state_d = S_MEMWB;
      S_MEMWR:  if (ready) state_d = S_FETCH;
      S_MEMWB:  state_d = S_FETCH;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FETCH;
    endcase
    if (timeout) state_d = S_FAULT;
  end

  // Wait counter tracks consecutive stalls and restarts on any state change;
  // fault latches one cycle after FAULT is first occupied.
  always_comb begin
    waitCnt_d = '0;
    if (WAIT_EN && isWaitState && !ready && (state_d == state_q)) begin
      waitCnt_d = waitCnt_q + 1'b1;
    end
    fault_d = fault_q | (state_q == S_FAULT);
  end

  // State, counter and sticky fault registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      waitCnt_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      fault_q   <= fault_d;
    end
  end

  // Moore output table; every output is held at zero while reset is asserted.
  always_comb begin
    ctrl.ir_w_o       = 1'b0;
    ctrl.pc_w_o       = 1'b0;
    ctrl.mem_w_o      = 1'b0;
    ctrl.adr_src_o    = ADR_PC;
    ctrl.alu_src_a_o  = SRCA_REG;
    ctrl.alu_src_b_o  = SRCB_REG;
    ctrl.result_src_o = RES_ALUOUT;
    ctrl.imm_src_o    = 2'b00;
    ctrl.reg_src_o    = 2'b00;
    ctrl.alu_ctl_o    = ALU_ADD;
    ctrl.flag_w_o     = 2'b00;
    ctrl.no_write_o   = 1'b0;
    ctrl.shift_o      = 1'b0;
    ctrl.fault_o      = 1'b0;
    ctrl.state_o      = 4'd0;
    regW              = 1'b0;
    branchW           = 1'b0;
    if (!reset) begin
      ctrl.imm_src_o  = ctrl.op_i;
      ctrl.reg_src_o  = {ctrl.op_i == 2'b01, ctrl.op_i == 2'b10};
      ctrl.alu_ctl_o  = decAluCtl;
      ctrl.flag_w_o   = decFlagW;
      ctrl.no_write_o = decNoWrite;
      ctrl.shift_o    = decShift;
      ctrl.fault_o    = fault_q;
      ctrl.state_o    = state_q;
      case (state_q)
        S_FETCH: begin
          ctrl.adr_src_o    = ADR_PC;
          ctrl.alu_src_a_o  = SRCA_PC;
          ctrl.alu_src_b_o  = SRCB_FOUR;
          ctrl.result_src_o = RES_ALU;
          ctrl.ir_w_o       = ready;
          ctrl.pc_w_o       = ready;
        end
        S_DECODE: begin
          ctrl.alu_src_a_o  = SRCA_PC;
          ctrl.alu_src_b_o  = SRCB_FOUR;
          ctrl.result_src_o = RES_ALU;
        end
        S_MEMADR: begin
          ctrl.alu_src_a_o = SRCA_REG;
          ctrl.alu_src_b_o = SRCB_IMM;
        end
        S_MEMRD: ctrl.adr_src_o = ADR_ALU;
        S_MEMWB: begin
          ctrl.result_src_o = RES_DATA;
          regW              = 1'b1;
        end
        S_MEMWR: begin
          ctrl.adr_src_o = ADR_ALU;
          ctrl.mem_w_o   = 1'b1;
        end
        S_EXECR: ctrl.alu_src_b_o = SRCB_REG;
        S_EXECI: ctrl.alu_src_b_o = SRCB_IMM;
        S_ALUWB: begin
          ctrl.result_src_o = RES_ALUOUT;
          regW              = ~cmdNoWrite(ctrl.funct_i[4:1]);
        end
        S_BRANCH: begin
          ctrl.alu_src_b_o  = SRCB_IMM;
          ctrl.result_src_o = RES_ALU;
          branchW           = 1'b1;
        end
        default: ;
      endcase
    end
    ctrl.reg_w_o  = regW;
    ctrl.branch_o = branchW;
    ctrl.pcs_o    = ((ctrl.rd_i == 4'hF) & regW) | branchW;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instructions, random instruction stream
// with random memory stalls, timeout fault and mid-instruction reset.
module tb_multicycle_controller;

  localparam int S_FETCH  = 0;
  localparam int S_DECODE = 1;
  localparam int S_MEMADR = 2;
  localparam int S_MEMRD  = 3;
  localparam int S_MEMWB  = 4;
  localparam int S_MEMWR  = 5;
  localparam int S_EXECR  = 6;
  localparam int S_EXECI  = 7;
  localparam int S_ALUWB  = 8;
  localparam int S_BRANCH = 9;
  localparam int S_FAULT  = 10;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  multicycle_controller_if bus ();

  multicycle_controller #(
    .MEM_HANDSHAKE (1'b1),
    .MAX_WAIT      (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Reference output vector for a state, built straight from the per-state table.
  function automatic logic [31:0] expectOuts(input int st, input bit rdy, input logic [1:0] op,
                                             input logic [5:0] f, input logic [3:0] rd);
    logic irW = 0, pcW = 0, br = 0, regW = 0, memW = 0, adr = 0, srcA = 0, noW = 0, sh = 0, pcs;
    logic [1:0] srcB = 0, res = 0, ctl = 0, flg = 0, regSrc;
    logic [3:0] cmd = f[4:1];
    case (st)
      S_FETCH:  begin srcA = 1; srcB = 2; res = 2; irW = rdy; pcW = rdy; end
      S_DECODE: begin srcA = 1; srcB = 2; res = 2; end
      S_MEMADR: srcB = 1;
      S_MEMRD:  adr = 1;
      S_MEMWB:  begin res = 1; regW = 1; end
      S_MEMWR:  begin adr = 1; memW = 1; end
      S_EXECR, S_EXECI: begin
        srcB = (st == S_EXECI) ? 2'd1 : 2'd0;
        if (cmd == 4'b0010 || cmd == 4'b1010) ctl = 1;
        else if (cmd == 4'b0000) ctl = 2;
        else if (cmd == 4'b1100) ctl = 3;
        noW = (cmd == 4'b1010);
        sh  = (cmd == 4'b1101);
        flg = {f[0], f[0] && (cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010)};
      end
      S_ALUWB:  regW = (cmd != 4'b1010);
      S_BRANCH: begin srcB = 1; res = 2; br = 1; end
      default: ;
    endcase
    pcs    = ((rd == 4'd15) && regW) || br;
    regSrc = {op == 2'b01, op == 2'b10};
    return {10'd0, irW, pcW, br, pcs, regW, memW, adr, srcA, srcB, res, op, regSrc, ctl, flg, noW, sh};
  endfunction

  function automatic logic [31:0] obsOuts();
    return {10'd0, bus.ir_w_o, bus.pc_w_o, bus.branch_o, bus.pcs_o, bus.reg_w_o, bus.mem_w_o,
            bus.adr_src_o, bus.alu_src_a_o, bus.alu_src_b_o, bus.result_src_o, bus.imm_src_o,
            bus.reg_src_o, bus.alu_ctl_o, bus.flag_w_o, bus.no_write_o, bus.shift_o};
  endfunction

  task automatic applyStimulus(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                               input bit rdy);
    bus.op_i        = op;
    bus.funct_i     = f;
    bus.rd_i        = rd;
    bus.mem_ready_i = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive, check at the falling edge, advance past the rising edge.
  task automatic stepCheck(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                           input bit rdy, input int expState, input int faultExp);
    applyStimulus(op, f, rd, rdy);
    @(negedge clk);
    checkOutput($sformatf("state(exp %0d)", expState), {28'd0, bus.state_o}, expState);
    checkOutput($sformatf("outs(st %0d)", expState), obsOuts(), expectOuts(expState, rdy, op, f, rd));
    if (faultExp >= 0) checkOutput("fault", {31'd0, bus.fault_o}, faultExp);
    @(posedge clk);
    #1;
  endtask

  // Reset cycle: all outputs must be zero, machine returns to FETCH.
  task automatic resetCycle(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                            input bit rdy);
    reset = 1'b1;
    applyStimulus(op, f, rd, rdy);
    @(negedge clk);
    checkOutput("reset_state", {28'd0, bus.state_o}, 0);
    checkOutput("reset_outs", obsOuts(), 0);
    checkOutput("reset_fault", {31'd0, bus.fault_o}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Expand one instruction into its expected state walk and replay it cycle by cycle.
  task automatic runInstr(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                          input int wFetch, input int wMem);
    int seq[$];
    bit rdy[$];
    for (int i = 0; i < wFetch; i++) begin seq.push_back(S_FETCH); rdy.push_back(1'b0); end
    seq.push_back(S_FETCH);  rdy.push_back(1'b1);
    seq.push_back(S_DECODE); rdy.push_back(1'($urandom));
    case (op)
      2'b00: begin
        seq.push_back(f[5] ? S_EXECI : S_EXECR); rdy.push_back(1'($urandom));
        seq.push_back(S_ALUWB);                  rdy.push_back(1'($urandom));
      end
      2'b01: begin
        seq.push_back(S_MEMADR); rdy.push_back(1'($urandom));
        for (int i = 0; i < wMem; i++) begin
          seq.push_back(f[0] ? S_MEMRD : S_MEMWR); rdy.push_back(1'b0);
        end
        seq.push_back(f[0] ? S_MEMRD : S_MEMWR); rdy.push_back(1'b1);
        if (f[0]) begin seq.push_back(S_MEMWB); rdy.push_back(1'($urandom)); end
      end
      2'b10: begin seq.push_back(S_BRANCH); rdy.push_back(1'($urandom)); end
      default: ;
    endcase
    for (int i = 0; i < seq.size(); i++) stepCheck(op, f, rd, rdy[i], seq[i], 0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence followed by a random instruction stream.
  initial begin
    logic [3:0] cmds [6];
    cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010, 4'b1101};
    reset = 1'b1;
    applyStimulus(2'b10, 6'b000000, 4'd15, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    resetCycle(2'b10, 6'b000000, 4'd15, 1'b1);

    runInstr(2'b00, 6'b001000, 4'd3, 0, 0);   // ADD register
    runInstr(2'b01, 6'b011001, 4'd5, 0, 2);   // LDR, two stalls in MEMRD
    runInstr(2'b00, 6'b110101, 4'd2, 0, 0);   // CMP immediate, S set
    runInstr(2'b10, 6'b000000, 4'd0, 0, 0);   // branch
    runInstr(2'b11, 6'b000000, 4'd0, 0, 0);   // undefined, NOP
    runInstr(2'b00, 6'b011010, 4'd15, 0, 0);  // MOV to PC
    runInstr(2'b01, 6'b000000, 4'd7, 3, 3);   // STR, stalls right up to the limit

    for (int n = 0; n < 40; n++) begin
      logic [1:0] op;
      logic [5:0] f;
      logic [3:0] rd;
      op = 2'($urandom_range(0, 3));
      f  = 6'($urandom);
      if (op == 2'b00 && $urandom_range(0, 3) != 0) f[4:1] = cmds[$urandom_range(0, 5)];
      rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
      runInstr(op, f, rd, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Stall forever in FETCH: three tolerated waits, fourth stall faults.
    for (int i = 0; i < 4; i++) stepCheck(2'b11, 6'd0, 4'd0, 1'b0, S_FETCH, 0);
    stepCheck(2'b11, 6'd0, 4'd0, 1'b0, S_FAULT, -1);
    stepCheck(2'b11, 6'd0, 4'd0, 1'b1, S_FAULT, 1);
    stepCheck(2'b11, 6'd0, 4'd0, 1'b1, S_FAULT, 1);
    resetCycle(2'b11, 6'd0, 4'd0, 1'b1);
    stepCheck(2'b11, 6'd0, 4'd0, 1'b1, S_FETCH, 0);
    stepCheck(2'b11, 6'd0, 4'd0, 1'b1, S_DECODE, 0);

    // Reset while a store is stalled in MEMWR.
    stepCheck(2'b01, 6'd0, 4'd4, 1'b1, S_FETCH, 0);
    stepCheck(2'b01, 6'd0, 4'd4, 1'b1, S_DECODE, 0);
    stepCheck(2'b01, 6'd0, 4'd4, 1'b1, S_MEMADR, 0);
    stepCheck(2'b01, 6'd0, 4'd4, 1'b0, S_MEMWR, 0);
    resetCycle(2'b01, 6'd0, 4'd4, 1'b0);
    stepCheck(2'b01, 6'd0, 4'd4, 1'b1, S_FETCH, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
